// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port byte-addressed RAM.
// Each requester presents valid/addr/wdata/we/lock; at most one is granted per
// cycle. A granted requester may lock the port for following beats. Reads get
// their response one cycle later, routed back by a registered owner tag;
// misaligned word/halfword requests are accepted but answered with an err pulse.
// Optional feature macro: RAM_ARBITER_RR_EN -- round-robin priority between the
// two requesters when both are valid and the port is unlocked (otherwise m0
// always wins).
module ram_arbiter #(
  parameter int SCALE = 10
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             m0_valid,
  output logic             m0_ready,
  input  logic [SCALE-1:0] m0_addr,
  input  logic [31:0]      m0_wdata,
  input  logic [3:0]       m0_we,
  input  logic             m0_lock,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,
  output logic             m0_err,

  input  logic             m1_valid,
  output logic             m1_ready,
  input  logic [SCALE-1:0] m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic [3:0]       m1_we,
  input  logic             m1_lock,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             m1_err,

  output logic             ram_oe,
  output logic [SCALE-1:0] ram_addr,
  output logic [31:0]      ram_wdata,
  output logic [3:0]       ram_we,
  input  logic [31:0]      ram_rdata,

  output logic [15:0]      grant_cnt
);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_t;

  lock_state_t state, state_next;

  logic gnt0, gnt1, any_gnt;
  logic [SCALE-1:0] sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_we;
  logic             sel_mis;

  // Response bookkeeping: which requester gets the read data / error next cycle.
  logic rd_pend0, rd_pend1;
  logic err_pend0, err_pend1;

  // Halfword at byte 3 straddles the word; a full word must be word-aligned.
  function automatic logic is_misaligned(input logic [3:0] we, input logic [1:0] lsb);
    return ((we == 4'b0011) && (lsb == 2'd3)) || ((we == 4'b1111) && (lsb != 2'd0));
  endfunction

`ifdef RAM_ARBITER_RR_EN
  // 0: m0 has priority on the next contended cycle, 1: m1 has priority.
  logic ptr;
`endif

  // Grant decision: lock owner first, then single requester, then priority.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      case (state)
        LOCK0:   gnt0 = m0_valid;
        LOCK1:   gnt1 = m1_valid;
        default: begin
          if (m0_valid && m1_valid) begin
`ifdef RAM_ARBITER_RR_EN
            gnt0 = ~ptr;
            gnt1 = ptr;
`else
            gnt0 = 1'b1;
`endif
          end else begin
            gnt0 = m0_valid;
            gnt1 = m1_valid;
          end
        end
      endcase
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign m0_ready = gnt0;
  assign m1_ready = gnt1;

  // Route the granted request onto the RAM port; misaligned beats never reach it.
  always_comb begin
    sel_addr  = gnt1 ? m1_addr  : m0_addr;
    sel_wdata = gnt1 ? m1_wdata : m0_wdata;
    sel_we    = gnt1 ? m1_we    : m0_we;
    sel_mis   = is_misaligned(sel_we, sel_addr[1:0]);
    ram_oe    = any_gnt && !sel_mis;
    ram_addr  = ram_oe ? sel_addr  : '0;
    ram_wdata = ram_oe ? sel_wdata : '0;
    ram_we    = ram_oe ? sel_we    : '0;
  end

  // Lock FSM next state: enter on a locked grant, leave on an unlocked grant
  // or when the owner goes idle with lock dropped.
  always_comb begin
    state_next = state;
    case (state)
      FREE: begin
        if (gnt0 && m0_lock)      state_next = LOCK0;
        else if (gnt1 && m1_lock) state_next = LOCK1;
      end
      LOCK0: begin
        if ((gnt0 && !m0_lock) || (!m0_valid && !m0_lock)) state_next = FREE;
      end
      LOCK1: begin
        if ((gnt1 && !m1_lock) || (!m1_valid && !m1_lock)) state_next = FREE;
      end
      default: state_next = FREE;
    endcase
  end

  // State, priority pointer, response tags and grant counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state     <= FREE;
      rd_pend0  <= 1'b0;
      rd_pend1  <= 1'b0;
      err_pend0 <= 1'b0;
      err_pend1 <= 1'b0;
      grant_cnt <= '0;
`ifdef RAM_ARBITER_RR_EN
      ptr       <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      rd_pend0  <= gnt0 && !sel_mis && (sel_we == 4'b0000);
      rd_pend1  <= gnt1 && !sel_mis && (sel_we == 4'b0000);
      err_pend0 <= gnt0 && sel_mis;
      err_pend1 <= gnt1 && sel_mis;
      if (any_gnt) grant_cnt <= grant_cnt + 16'd1;
`ifdef RAM_ARBITER_RR_EN
      if (any_gnt) ptr <= gnt0;
`endif
    end
  end

  // Responses are masked while reset is held so a read issued just before
  // reset never reports back.
  assign m0_rvalid = rd_pend0 & rst;
  assign m1_rvalid = rd_pend1 & rst;
  assign m0_err    = err_pend0 & rst;
  assign m1_err    = err_pend1 & rst;
  assign m0_rdata  = m0_rvalid ? ram_rdata : 32'd0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : 32'd0;

endmodule
